// File: rtl/ctrl_pipe.sv
// Control-word pipeline with per-stage stall/flush and bubble insertion behind held stages.
// Optional bubble counter on the last stage is compiled in with `define CTRL_PIPE_PERF_EN.
module ctrl_pipe #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       ctrl_d,
  input  logic                   valid_d,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic [DEPTH*WIDTH-1:0] ctrl_q,
  output logic [DEPTH-1:0]       valid_q,
  output logic                   stall_d
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]            bubble_cnt
`endif
);

  logic [DEPTH-1:0] hold;
  logic [WIDTH-1:0] stageWord [DEPTH];
  logic             stageValid [DEPTH];

  // A stage is held if it or any stage downstream of it stalls.
  for (genvar k = 0; k < DEPTH; k++) begin : gHold
    assign hold[k] = |stall[DEPTH-1:k];
  end

  assign stall_d = hold[0];

  for (genvar k = 0; k < DEPTH; k++) begin : gStage
    logic [WIDTH-1:0] upWord;
    logic             upValid;

    if (k == 0) begin : gFirst
      assign upWord  = valid_d ? ctrl_d : '0;
      assign upValid = valid_d;
    end else begin : gNext
      // Behind a held upstream stage we take a bubble so the held word is not duplicated.
      assign upWord  = hold[k-1] ? '0 : stageWord[k-1];
      assign upValid = hold[k-1] ? 1'b0 : stageValid[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stageWord[k]  <= '0;
        stageValid[k] <= 1'b0;
      end else if (flush[k]) begin
        stageWord[k]  <= '0;
        stageValid[k] <= 1'b0;
      end else if (!hold[k]) begin
        stageWord[k]  <= upWord;
        stageValid[k] <= upValid;
      end
    end

    assign ctrl_q[k*WIDTH +: WIDTH] = stageWord[k];
    assign valid_q[k]               = stageValid[k];
  end

`ifdef CTRL_PIPE_PERF_EN
  // Counts edges where an empty last stage is allowed to advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!stageValid[DEPTH-1] && !hold[DEPTH-1]) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios followed by random stall/flush traffic
// compared against a behavioural pipeline model; honours CTRL_PIPE_PERF_EN for the counter.
module tb_ctrl_pipe;
  localparam int WIDTH = 11;
  localparam int DEPTH = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WIDTH-1:0]       ctrl_d;
  logic                   valid_d;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic [DEPTH*WIDTH-1:0] ctrl_q;
  logic [DEPTH-1:0]       valid_q;
  logic                   stall_d;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0]            bubble_cnt;
`endif

  ctrl_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_d    (ctrl_d),
    .valid_d   (valid_d),
    .stall     (stall),
    .flush     (flush),
    .ctrl_q    (ctrl_q),
    .valid_q   (valid_q),
    .stall_d   (stall_d)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of each stage as the architecture defines them.
  logic [WIDTH-1:0] mWord [DEPTH];
  logic             mValid [DEPTH];
  logic [31:0]      mCnt;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stage k is held when any stage at position k or later asks to stall.
  function automatic logic isHeld(input logic [DEPTH-1:0] s, input int k);
    return (s >> k) != 0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < DEPTH; k++) begin
      mWord[k]  = '0;
      mValid[k] = 1'b0;
    end
    mCnt = '0;
  endtask

  task automatic modelEdge();
    logic [WIDTH-1:0] nWord [DEPTH];
    logic             nValid [DEPTH];
    if (!mValid[DEPTH-1] && !isHeld(stall, DEPTH-1)) mCnt = mCnt + 1;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush[k]) begin
        nWord[k] = '0; nValid[k] = 1'b0;
      end else if (isHeld(stall, k)) begin
        nWord[k] = mWord[k]; nValid[k] = mValid[k];
      end else if (k == 0) begin
        nWord[k] = valid_d ? ctrl_d : '0; nValid[k] = valid_d;
      end else if (isHeld(stall, k - 1)) begin
        nWord[k] = '0; nValid[k] = 1'b0;
      end else begin
        nWord[k] = mWord[k-1]; nValid[k] = mValid[k-1];
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      mWord[k]  = nWord[k];
      mValid[k] = nValid[k];
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [DEPTH*WIDTH-1:0] expWords;
    logic [DEPTH-1:0]       expValid;
    for (int k = 0; k < DEPTH; k++) begin
      expWords[k*WIDTH +: WIDTH] = mWord[k];
      expValid[k]                = mValid[k];
    end
    checkValue({tag, ".ctrl_q"}, 64'(ctrl_q), 64'(expWords));
    checkValue({tag, ".valid_q"}, 64'(valid_q), 64'(expValid));
`ifdef CTRL_PIPE_PERF_EN
    checkValue({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(mCnt));
`endif
  endtask

  // Called at a falling edge: drive inputs, check stall_d, take one rising edge, check state.
  task automatic applyStimulus(input logic [WIDTH-1:0] w, input logic v,
                               input logic [DEPTH-1:0] s, input logic [DEPTH-1:0] f,
                               input string tag);
    ctrl_d  = w;
    valid_d = v;
    stall   = s;
    flush   = f;
    #1;
    checkValue({tag, ".stall_d"}, 64'(stall_d), 64'(isHeld(s, 0)));
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  function automatic logic [WIDTH-1:0] stageOf(input int k);
    return ctrl_q[k*WIDTH +: WIDTH];
  endfunction

  initial begin
    rst = 1'b1; ctrl_d = '0; valid_d = 1'b0; stall = '0; flush = '0;
    modelReset();
    @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;

    // Streaming: stage 2 shows 1, 2, 3 after edges 3, 4, 5.
    applyStimulus(11'h001, 1'b1, '0, '0, "stream1");
    applyStimulus(11'h002, 1'b1, '0, '0, "stream2");
    applyStimulus(11'h003, 1'b1, '0, '0, "stream3");
    checkValue("stream.s2a", 64'(stageOf(2)), 64'h001);
    applyStimulus('0, 1'b0, '0, '0, "stream4");
    checkValue("stream.s2b", 64'(stageOf(2)), 64'h002);
    applyStimulus('0, 1'b0, '0, '0, "stream5");
    checkValue("stream.s2c", 64'(stageOf(2)), 64'h003);
    checkValue("stream.v2", 64'(valid_q[2]), 64'h1);

    // Mid stall with 0x005 held in stage 1.
    applyStimulus(11'h004, 1'b1, '0, '0, "fill4");
    applyStimulus(11'h005, 1'b1, '0, '0, "fill5");
    applyStimulus(11'h006, 1'b1, '0, '0, "fill6");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(11'h007, 1'b1, 3'b010, '0, "midstall");
      checkValue("midstall.s1", 64'(stageOf(1)), 64'h005);
      checkValue("midstall.s0", 64'(stageOf(0)), 64'h006);
      checkValue("midstall.v2", 64'(valid_q[2]), 64'h0);
    end
    applyStimulus(11'h007, 1'b1, '0, '0, "resume1");
    checkValue("resume.s2", 64'(stageOf(2)), 64'h005);
    applyStimulus('0, 1'b0, '0, '0, "resume2");
    checkValue("resume.s2b", 64'(stageOf(2)), 64'h006);

    // Flush wins over stall on stage 0.
    applyStimulus(11'h7FF, 1'b1, '0, '0, "flushprep");
    applyStimulus('0, 1'b0, 3'b001, 3'b001, "flushstall");
    checkValue("flushstall.s0", 64'(stageOf(0)), 64'h0);
    checkValue("flushstall.v0", 64'(valid_q[0]), 64'h0);

    // Async reset between edges with all stages valid.
    applyStimulus(11'h011, 1'b1, '0, '0, "prerst1");
    applyStimulus(11'h022, 1'b1, '0, '0, "prerst2");
    applyStimulus(11'h033, 1'b1, '0, '0, "prerst3");
    checkValue("prerst.valid", 64'(valid_q), 64'h7);
    rst = 1'b1;
    #1;
    checkValue("asyncrst.ctrl", 64'(ctrl_q), 64'h0);
    checkValue("asyncrst.valid", 64'(valid_q), 64'h0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(11'h044, 1'b1, '0, '0, "postrst");

    // Bubble input: word is zeroed on entry.
    applyStimulus(11'h3FF, 1'b0, '0, '0, "bubblein");
    checkValue("bubblein.s0", 64'(stageOf(0)), 64'h0);
    applyStimulus('0, 1'b0, '0, '0, "drain1");
    applyStimulus('0, 1'b0, '0, '0, "drain2");
    applyStimulus('0, 1'b0, '0, '0, "drain3");

`ifdef CTRL_PIPE_PERF_EN
    force dut.bubble_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt;
    mCnt = 32'hFFFF_FFFF;
    applyStimulus('0, 1'b0, '0, '0, "wrap");
    checkValue("wrap.cnt", 64'(bubble_cnt), 64'h0);
`endif

    // Random traffic with sparse stalls, flushes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [DEPTH-1:0] s;
      logic [DEPTH-1:0] f;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rndrst");
        @(negedge clk);
        rst = 1'b0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        s[k] = ($urandom_range(0, 5) == 0);
        f[k] = ($urandom_range(0, 9) == 0);
      end
      applyStimulus(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'($urandom_range(0, 3) != 0),
                    s, f, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter WIDTH, default 11, bits per control word carried per stage.
REQ-002 Parameter DEPTH, default 3, number of pipeline stages after decode (stage 0 = E, 1 = M, 2 = W); legal range 1..6.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port ctrl_d  input  WIDTH  decoded control word entering stage 0.
REQ-006 Port valid_d  input  1  ctrl_d is a real instruction (0 = bubble).
REQ-007 Port stall  input  DEPTH  per-stage stall request, bit k for stage k.
REQ-008 Port flush  input  DEPTH  per-stage flush request, bit k for stage k.
REQ-009 Port ctrl_q  output  DEPTH*WIDTH  stage-k word at bits [k*WIDTH +: WIDTH].
REQ-010 Port valid_q  output  DEPTH  per-stage valid bit.
REQ-011 Port stall_d  output  1  decode-stage hold request; high when stage 0 is held.
REQ-012 Port bubble_cnt  output  32  bubble counter; present only under CTRL_PIPE_PERF_EN.

Function
REQ-013 Hold for stage k SHALL be hold[k] = OR of stall[j] for j = k..DEPTH-1; a stall propagates to all upstream stages.
REQ-014 stall_d SHALL equal hold[0], combinationally.
REQ-015 Per-stage priority each edge: flush[k] first; then hold[k]; then load from upstream.
REQ-016 Flush SHALL load word 0 and valid 0 into stage k, even when hold[k] is 1.
REQ-017 Hold without flush SHALL keep stage k word and valid unchanged.
REQ-018 Load, k = 0: stage 0 SHALL take {ctrl_d, valid_d}; when valid_d = 0, it SHALL take word 0.
REQ-019 Load, k > 0, hold[k-1] = 0: stage k SHALL take stage k-1 word and valid.
REQ-020 Load, k > 0, hold[k-1] = 1: stage k SHALL load a bubble (word 0, valid 0) so a held instruction is never duplicated.
REQ-021 Invariant: valid_q[k] = 0 SHALL imply stage-k word is all zeros.
REQ-022 Latency: a word presented at ctrl_d with no stall or flush SHALL appear at stage k after k+1 rising edges.
REQ-023 Flush and stall on the same stage in the same cycle SHALL resolve as flush.
REQ-024 stall on the last stage SHALL freeze the whole pipe; stage contents SHALL NOT change until it drops, except stages with flush asserted.

Reset
REQ-025 rst high SHALL asynchronously clear all stage words, valid_q and bubble_cnt to 0; stall_d then follows stall inputs.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight words; the first edge after deassertion SHALL load stage 0 normally.

Configuration
REQ-027 Macro CTRL_PIPE_PERF_EN compiles in the bubble counter.
REQ-028 With CTRL_PIPE_PERF_EN: bubble_cnt SHALL increment by 1 on each edge where valid_q[DEPTH-1] = 0 and hold[DEPTH-1] = 0, and SHALL wrap 0xFFFFFFFF -> 0.
REQ-029 Without CTRL_PIPE_PERF_EN: the bubble_cnt port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Stream: DEPTH=3, WIDTH=11, ctrl_d = 0x001, 0x002, 0x003 with valid_d = 1 on successive cycles -> stage 2 shows 0x001, 0x002, 0x003 on cycles 3, 4, 5 with valid_q[2] = 1.
REQ-031 Mid stall: stall[1] = 1 for 2 cycles while stage 1 holds 0x005 -> stage 1 stays 0x005, stage 0 frozen, stall_d = 1, stage 2 gets word 0 with valid 0 for 2 cycles, then the stream resumes without duplicating or losing a word.
REQ-032 Flush over stall: flush[0] = 1 and stall[0] = 1 with stage 0 = 0x7FF -> next cycle stage 0 word 0, valid_q[0] = 0.
REQ-033 Async reset: assert rst between edges with all stages valid -> ctrl_q = 0 and valid_q = 0 immediately, before the next edge.
REQ-034 Bubble input: valid_d = 0 with ctrl_d = 0x3FF -> stage 0 word 0, valid 0; under CTRL_PIPE_PERF_EN, bubble_cnt increments 3 cycles later.
REQ-035 Counter wrap: under CTRL_PIPE_PERF_EN, force bubble_cnt to 0xFFFFFFFF, then one bubble reaches the last stage -> bubble_cnt = 0.
